// File: rtl/order_queue_sched_if.sv
// Bundle between the tag scheduler, its requesters, the order queue and retire logic.
// Handshakes: a requester holds req until it sees gnt at a rising edge; a retire transfer
// happens on a rising edge where retire_valid && retire_ready, which is exactly q_rd_en.
interface order_queue_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 5
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*TAG_W-1:0] tag_in;
  logic [NUM_REQ-1:0]       gnt;
  logic                     flush;
  logic                     busy;
  logic                     q_wr_en;
  logic [TAG_W-1:0]         q_data_in;
  logic                     q_clear;
  logic                     q_rd_en;
  logic                     q_full;
  logic                     q_empty;
  logic [TAG_W-1:0]         q_data_out;
  logic                     retire_ready;
  logic                     retire_valid;
  logic [TAG_W-1:0]         retire_tag;

  modport master (
    input  req, tag_in, flush, q_full, q_empty, q_data_out, retire_ready,
    output gnt, busy, q_wr_en, q_data_in, q_clear, q_rd_en, retire_valid, retire_tag
  );

  modport slave (
    output req, tag_in, flush, q_full, q_empty, q_data_out, retire_ready,
    input  gnt, busy, q_wr_en, q_data_in, q_clear, q_rd_en, retire_valid, retire_tag
  );
endinterface

// File: rtl/order_queue_sched.sv
// Rotating-priority write arbiter and retire handshake around one shared order queue,
// with a flush sequence of one clear cycle followed by a programmable hold-off.
module order_queue_sched #(
  parameter int NUM_REQ     = 4,
  parameter int TAG_W       = 5,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  order_queue_sched_if.master      bus,
  output logic [1:0]               dbg_state_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] HOLD_INIT = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]       hold_cnt_q, hold_cnt_d;

  logic             found;
  logic [PTR_W-1:0] win_idx;

  // Cyclic scan starting at rr_ptr; first set request wins.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] idx_sel;
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    idx_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx     = (int'(rr_ptr_q) + k) % NUM_REQ;
      idx_sel = PTR_W'(idx);
      if (!found && bus.req[idx_sel]) begin
        found   = 1'b1;
        win_idx = idx_sel;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    hold_cnt_d       = hold_cnt_q;
    bus.gnt          = '0;
    bus.q_wr_en      = 1'b0;
    bus.q_data_in    = '0;
    bus.q_clear      = 1'b0;
    bus.q_rd_en      = 1'b0;
    bus.retire_valid = 1'b0;
    bus.retire_tag   = bus.q_data_out;
    bus.busy         = (state_q != ST_RUN);
    dbg_state_o      = state_q;

    case (state_q)
      ST_RUN: begin
        if (bus.flush) begin
          state_d = ST_FLUSH;
        end else begin
          bus.retire_valid = !bus.q_empty;
          bus.q_rd_en      = !bus.q_empty && bus.retire_ready;
          // q_full is the pre-pop level, so a simultaneous pop never frees a slot.
          if (found && !bus.q_full) begin
            bus.gnt[win_idx] = 1'b1;
            bus.q_wr_en      = 1'b1;
            bus.q_data_in    = bus.tag_in[TAG_W*int'(win_idx) +: TAG_W];
            if (int'(win_idx) == NUM_REQ - 1) rr_ptr_d = '0;
            else                              rr_ptr_d = win_idx + PTR_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        bus.q_clear = 1'b1;
        rr_ptr_d    = '0;
        hold_cnt_d  = HOLD_INIT;
        if (bus.flush)             state_d = ST_FLUSH;
        else if (HOLD_CYCLES == 0) state_d = ST_RUN;
        else                       state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.flush) begin
          state_d = ST_FLUSH;
        end else if (hold_cnt_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Reset forces every output low regardless of the registered state.
    if (reset) begin
      bus.gnt          = '0;
      bus.q_wr_en      = 1'b0;
      bus.q_data_in    = '0;
      bus.q_clear      = 1'b0;
      bus.q_rd_en      = 1'b0;
      bus.retire_valid = 1'b0;
      bus.retire_tag   = '0;
      bus.busy         = 1'b0;
      dbg_state_o      = 2'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_RUN;
      rr_ptr_q   <= '0;
      hold_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: tb/tb_order_queue_sched.sv
// Directed cycle-by-cycle bench for order_queue_sched: a vector table plus hand-built
// flush/reset sequences, each row checked against hand-computed outputs.
module tb_order_queue_sched;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 5;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  int row_no  = 0;

  order_queue_sched_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

  order_queue_sched #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .HOLD_CYCLES(2)) dut (
    .clock       (clk),
    .reset       (rst),
    .bus         (bus.master),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       flush;
    logic       full;
    logic       empty;
    logic [4:0] dout;
    logic       ready;
    logic [3:0] e_gnt;
    logic       e_wr;
    logic [4:0] e_data;
    logic       e_clr;
    logic       e_rd;
    logic       e_busy;
    logic       e_rv;
    logic [4:0] e_tag;
    logic [1:0] e_st;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic [3:0] rq, input logic fl, input logic fu, input logic em,
    input logic [4:0] dout, input logic rdy,
    input logic [3:0] g, input logic wr, input logic [4:0] d, input logic clr,
    input logic rd, input logic bsy, input logic rv, input logic [4:0] tg, input logic [1:0] st);
    vec_t v;
    v.rst = r; v.req = rq; v.flush = fl; v.full = fu; v.empty = em; v.dout = dout; v.ready = rdy;
    v.e_gnt = g; v.e_wr = wr; v.e_data = d; v.e_clr = clr; v.e_rd = rd; v.e_busy = bsy;
    v.e_rv = rv; v.e_tag = tg; v.e_st = st;
    return v;
  endfunction

  // driver
  task automatic drive(input vec_t v);
    rst              = v.rst;
    bus.req          = v.req;
    bus.tag_in       = {5'd4, 5'd3, 5'd2, 5'd1};
    bus.flush        = v.flush;
    bus.q_full       = v.full;
    bus.q_empty      = v.empty;
    bus.q_data_out   = v.dout;
    bus.retire_ready = v.ready;
  endtask

  // scoreboard
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s row %0d: got %0h expected %0h", name, row_no, act, exp);
    else
      n_pass++;
  endtask

  task automatic check(input vec_t v);
    cmp("gnt",          32'(bus.gnt),          32'(v.e_gnt));
    cmp("q_wr_en",      32'(bus.q_wr_en),      32'(v.e_wr));
    cmp("q_data_in",    32'(bus.q_data_in),    32'(v.e_data));
    cmp("q_clear",      32'(bus.q_clear),      32'(v.e_clr));
    cmp("q_rd_en",      32'(bus.q_rd_en),      32'(v.e_rd));
    cmp("busy",         32'(bus.busy),         32'(v.e_busy));
    cmp("retire_valid", 32'(bus.retire_valid), 32'(v.e_rv));
    cmp("retire_tag",   32'(bus.retire_tag),   32'(v.e_tag));
    cmp("state",        32'(dbg_state),        32'(v.e_st));
  endtask

  // Drive after the rising edge, check at the falling edge, then advance one cycle.
  task automatic run_vec(input vec_t v);
    drive(v);
    @(negedge clk);
    check(v);
    row_no++;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[18];

  initial begin
    //              rst req     fl fu em dout ry | gnt     wr data clr rd bsy rv tag st
    vecs[0]  = mk(1, 4'b1111, 0, 0, 1, 5'd0, 0,  4'b0000, 0, 5'd0, 0, 0, 0, 0, 5'd0, S_RUN);
    vecs[1]  = mk(0, 4'b1111, 0, 0, 1, 5'd0, 0,  4'b0001, 1, 5'd1, 0, 0, 0, 0, 5'd0, S_RUN);
    vecs[2]  = mk(0, 4'b1111, 0, 0, 1, 5'd0, 0,  4'b0010, 1, 5'd2, 0, 0, 0, 0, 5'd0, S_RUN);
    vecs[3]  = mk(0, 4'b1111, 0, 0, 1, 5'd0, 0,  4'b0100, 1, 5'd3, 0, 0, 0, 0, 5'd0, S_RUN);
    vecs[4]  = mk(0, 4'b1111, 0, 0, 1, 5'd0, 0,  4'b1000, 1, 5'd4, 0, 0, 0, 0, 5'd0, S_RUN);
    // rr_ptr 0 -> grant 1 moves it to 2; then 0011 wraps to requester 0
    vecs[5]  = mk(0, 4'b0010, 0, 0, 1, 5'd0, 0,  4'b0010, 1, 5'd2, 0, 0, 0, 0, 5'd0, S_RUN);
    vecs[6]  = mk(0, 4'b0011, 0, 0, 1, 5'd0, 0,  4'b0001, 1, 5'd1, 0, 0, 0, 0, 5'd0, S_RUN);
    vecs[7]  = mk(0, 4'b0011, 0, 0, 1, 5'd0, 0,  4'b0010, 1, 5'd2, 0, 0, 0, 0, 5'd0, S_RUN);
    // full blocks, then release the same cycle; rr_ptr=2 so requester 0 wins by wrap
    vecs[8]  = mk(0, 4'b0001, 0, 1, 1, 5'd0, 0,  4'b0000, 0, 5'd0, 0, 0, 0, 0, 5'd0, S_RUN);
    vecs[9]  = mk(0, 4'b0001, 0, 0, 1, 5'd0, 0,  4'b0001, 1, 5'd1, 0, 0, 0, 0, 5'd0, S_RUN);
    // pop while full: no grant
    vecs[10] = mk(0, 4'b1111, 0, 1, 0, 5'd7, 1,  4'b0000, 0, 5'd0, 0, 1, 0, 1, 5'd7, S_RUN);
    vecs[11] = mk(0, 4'b0000, 0, 0, 0, 5'd7, 0,  4'b0000, 0, 5'd0, 0, 0, 0, 1, 5'd7, S_RUN);
    // write and pop together; rr_ptr=1 so requester 2 wins
    vecs[12] = mk(0, 4'b0100, 0, 0, 0, 5'd9, 1,  4'b0100, 1, 5'd3, 0, 1, 0, 1, 5'd9, S_RUN);
    // flush pulse then FLUSH, HOLD, HOLD, RUN restarting at requester 0
    vecs[13] = mk(0, 4'b1111, 1, 0, 1, 5'd0, 0,  4'b0000, 0, 5'd0, 0, 0, 0, 0, 5'd0, S_RUN);
    vecs[14] = mk(0, 4'b1111, 0, 0, 0, 5'd7, 1,  4'b0000, 0, 5'd0, 1, 0, 1, 0, 5'd7, S_FLUSH);
    vecs[15] = mk(0, 4'b1111, 0, 0, 0, 5'd7, 1,  4'b0000, 0, 5'd0, 0, 0, 1, 0, 5'd7, S_HOLD);
    vecs[16] = mk(0, 4'b1111, 0, 0, 0, 5'd7, 1,  4'b0000, 0, 5'd0, 0, 0, 1, 0, 5'd7, S_HOLD);
    vecs[17] = mk(0, 4'b1111, 0, 0, 0, 5'd7, 1,  4'b0001, 1, 5'd1, 0, 1, 0, 1, 5'd7, S_RUN);

    drive(vecs[0]);
    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // flush again in HOLD: FLUSH repeats and busy lasts three more cycles
    run_vec(mk(0, 4'b0000, 1, 0, 1, 5'd0, 0,  4'b0000, 0, 5'd0, 0, 0, 0, 0, 5'd0, S_RUN));
    run_vec(mk(0, 4'b0000, 0, 0, 1, 5'd0, 0,  4'b0000, 0, 5'd0, 1, 0, 1, 0, 5'd0, S_FLUSH));
    run_vec(mk(0, 4'b0000, 1, 0, 1, 5'd0, 0,  4'b0000, 0, 5'd0, 0, 0, 1, 0, 5'd0, S_HOLD));
    run_vec(mk(0, 4'b1111, 0, 0, 1, 5'd0, 0,  4'b0000, 0, 5'd0, 1, 0, 1, 0, 5'd0, S_FLUSH));
    run_vec(mk(0, 4'b1111, 0, 0, 1, 5'd0, 0,  4'b0000, 0, 5'd0, 0, 0, 1, 0, 5'd0, S_HOLD));
    run_vec(mk(0, 4'b1111, 0, 0, 1, 5'd0, 0,  4'b0000, 0, 5'd0, 0, 0, 1, 0, 5'd0, S_HOLD));
    run_vec(mk(0, 4'b1111, 0, 0, 1, 5'd0, 0,  4'b0001, 1, 5'd1, 0, 0, 0, 0, 5'd0, S_RUN));

    // reset asserted in HOLD: outputs low at once, RUN with rr_ptr 0 afterwards
    run_vec(mk(0, 4'b0000, 1, 0, 1, 5'd0, 0,  4'b0000, 0, 5'd0, 0, 0, 0, 0, 5'd0, S_RUN));
    run_vec(mk(0, 4'b0000, 0, 0, 1, 5'd0, 0,  4'b0000, 0, 5'd0, 1, 0, 1, 0, 5'd0, S_FLUSH));
    run_vec(mk(1, 4'b1111, 0, 0, 0, 5'd0, 1,  4'b0000, 0, 5'd0, 0, 0, 0, 0, 5'd0, S_RUN));
    run_vec(mk(0, 4'b0000, 0, 0, 1, 5'd0, 0,  4'b0000, 0, 5'd0, 0, 0, 0, 0, 5'd0, S_RUN));
    run_vec(mk(0, 4'b1111, 0, 0, 1, 5'd0, 0,  4'b0001, 1, 5'd1, 0, 0, 0, 0, 5'd0, S_RUN));
    run_vec(mk(0, 4'b1111, 0, 0, 1, 5'd0, 0,  4'b0010, 1, 5'd2, 0, 0, 0, 0, 5'd0, S_RUN));

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
